// File: rtl/tick_div_pkg.sv
// Shared constants and helpers for the tick divider bank.
// Divisors are expressed as a period in system clock cycles.
package tick_div_pkg;

  localparam int unsigned CLK_FREQ_DEFAULT = 20_000_000;
  localparam int CW_DEFAULT = 32;
  localparam int NCH_DEFAULT = 4;
  localparam int CHW_DEFAULT = $clog2(NCH_DEFAULT) + 1;

  function automatic int unsigned hz_to_div(
    input int unsigned clk_hz,
    input int unsigned f_hz
  );
    return clk_hz / f_hz;
  endfunction

  // One extra bit so out-of-range channels can be addressed.
  function automatic int ch_w(input int nch);
    return $clog2(nch) + 1;
  endfunction

endpackage

// File: rtl/tick_divider_bank_if.sv
// Divisor configuration port with valid/ready handshake
// and an error pulse for writes to nonexistent channels.
interface tick_divider_bank_if
  import tick_div_pkg::*;
#(
  parameter int CHW = CHW_DEFAULT,
  parameter int CW  = CW_DEFAULT
);

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_div;
  logic           cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/tick_div_chan.sv
// One clock-enable channel: period counter, tick/square outputs
// and a pending divisor that applies only at a period boundary.
module tick_div_chan
  import tick_div_pkg::*;
#(
  parameter int          CW          = CW_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 20_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          sync_clr,
  input  logic          wr,
  input  logic [CW-1:0] wr_div,
  output logic          pend_vld,
  output logic          tick,
  output logic          sq
);

  logic [CW-1:0] count;
  logic [CW-1:0] div;
  logic [CW-1:0] pend_div;
  logic          running;
  logic          term;
  logic          apply;

  assign running = en && (div != '0);
  assign term    = running && (count == div - CW'(1));
  assign apply   = pend_vld && (term || !running || sync_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      div      <= CW'(DEFAULT_DIV);
      pend_div <= '0;
      pend_vld <= 1'b0;
      tick     <= 1'b0;
      sq       <= 1'b0;
    end else begin
      tick <= term && !sync_clr;
      sq   <= running && (count >= (div >> 1));
      // wr is only issued while nothing is pending, so it never races apply.
      if (apply) begin
        div      <= pend_div;
        pend_vld <= 1'b0;
      end else if (wr) begin
        pend_div <= wr_div;
        pend_vld <= 1'b1;
      end
      if (sync_clr || apply || !running || term)
        count <= '0;
      else
        count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/tick_divider_bank.sv
// Bank of programmable clock-enable generators sharing one
// config port; channel decode, ready mux and error flag live here.
module tick_divider_bank
  import tick_div_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = CLK_FREQ_DEFAULT,
  parameter int          NCH         = NCH_DEFAULT,
  parameter int          CW          = CW_DEFAULT,
  parameter int unsigned DEFAULT_DIV = hz_to_div(CLK_FREQ, 1000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      en,
  input  logic                sync_clr,
  tick_divider_bank_if.slave  cfg,
  output logic [NCH-1:0]      tick,
  output logic [NCH-1:0]      sq
);

  localparam int CHW = ch_w(NCH);

  logic [NCH-1:0] pend_vld;
  logic [NCH-1:0] wr;
  logic           ready;
  logic           oor;
  logic           err;

  assign oor = cfg.cfg_ch >= CHW'(NCH);

  always_comb begin
    ready = 1'b1;
    wr    = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) begin
        ready = !pend_vld[i];
        wr[i] = cfg.cfg_valid && !pend_vld[i];
      end
    end
  end

  assign cfg.cfg_ready = ready;
  assign cfg.cfg_err   = err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else
      err <= cfg.cfg_valid && oor;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_div_chan #(
      .CW          (CW),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[g]),
      .sync_clr (sync_clr),
      .wr       (wr[g]),
      .wr_div   (cfg.cfg_div),
      .pend_vld (pend_vld[g]),
      .tick     (tick[g]),
      .sq       (sq[g])
    );
  end

endmodule

// File: tb/tb_tick_divider_bank.sv
// Directed bench for tick_divider_bank with DEFAULT_DIV=8, NCH=4.
// Sampling happens 1 time unit after each rising edge.
module tb_tick_divider_bank;

  logic       clk;
  logic       rst;
  logic       sync_clr;
  logic [3:0] en;
  logic [3:0] tick;
  logic [3:0] sq;
  logic [3:0] e;
  int         vectors;
  int         miscompares;
  int         nwait;

  tick_divider_bank_if #(.CHW(3), .CW(32)) cfg ();

  tick_divider_bank #(
    .CLK_FREQ    (20_000_000),
    .NCH         (4),
    .CW          (32),
    .DEFAULT_DIV (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .cfg      (cfg),
    .tick     (tick),
    .sq       (sq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [2:0]  ch,
    input logic [31:0] d,
    input string       tag
  );
    cfg.cfg_ch  = ch;
    cfg.cfg_div = d;
    #1;
    chk(tag, 32'(cfg.cfg_ready), 32'(1));
    cfg.cfg_valid = 1'b1;
    step();
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    en = 4'b0000;
    sync_clr = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = 3'd0;
    cfg.cfg_div = 32'd0;
    repeat (3) step();
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_sq", 32'(sq), 32'(0));
    chk("rst_err", 32'(cfg.cfg_err), 32'(0));
    chk("rst_rdy", 32'(cfg.cfg_ready), 32'(1));

    // 1: default divisor 8 on channel 0
    en = 4'b0001;
    rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      step();
      e = '0;
      e[0] = (k % 8 == 0);
      chk("t1_tick", 32'(tick), 32'(e));
      chk("t1_sq0", 32'(sq[0]), 32'(((k - 1) % 8) >= 4));
    end

    // 2: reprogram ch1 mid-period; second write held off
    en = 4'b0011;
    for (int j = 1; j <= 18; j++) begin
      if (j == 4) begin
        cfg.cfg_ch = 3'd1;
        cfg.cfg_div = 32'd5;
        #1;
        chk("t2_rdy_a", 32'(cfg.cfg_ready), 32'(1));
        cfg.cfg_valid = 1'b1;
      end
      if (j >= 5 && j <= 8) begin
        cfg.cfg_div = 32'd3;
        #1;
        chk("t2_hold", 32'(cfg.cfg_ready), 32'(0));
      end
      if (j == 9) begin
        cfg.cfg_valid = 1'b0;
        #1;
        chk("t2_rdy_b", 32'(cfg.cfg_ready), 32'(1));
      end
      step();
      chk("t2_tick1", 32'(tick[1]),
          32'(j == 8 || j == 13 || j == 18));
      if (j <= 8)
        chk("t2_sq1", 32'(sq[1]), 32'((j - 1) >= 4));
      else
        chk("t2_sq1", 32'(sq[1]), 32'(((j - 9) % 5) >= 2));
    end

    // 3: ch2 div 0, then 1, then 3
    wr(3'd2, 32'd0, "t3_rdy0");
    step();
    en = 4'b0111;
    for (int m = 0; m < 4; m++) begin
      step();
      chk("t3_d0_tick", 32'(tick[2]), 32'(0));
      chk("t3_d0_sq", 32'(sq[2]), 32'(0));
    end
    wr(3'd2, 32'd1, "t3_rdy1");
    step();
    chk("t3_d1_apply", 32'(tick[2]), 32'(0));
    for (int m = 0; m < 4; m++) begin
      step();
      chk("t3_d1_tick", 32'(tick[2]), 32'(1));
      chk("t3_d1_sq", 32'(sq[2]), 32'(1));
    end
    wr(3'd2, 32'd3, "t3_rdy3");
    chk("t3_acc_tick", 32'(tick[2]), 32'(1));
    step();
    chk("t3_app_tick", 32'(tick[2]), 32'(1));
    for (int m = 1; m <= 6; m++) begin
      step();
      chk("t3_d3_tick", 32'(tick[2]), 32'(((m - 1) % 3) == 2));
      chk("t3_d3_sq", 32'(sq[2]), 32'(((m - 1) % 3) >= 1));
    end

    // 4: ch2 div 6, enable dropped at count 3
    en = 4'b0011;
    step();
    wr(3'd2, 32'd6, "t4_rdy");
    step();
    en = 4'b0111;
    for (int m = 0; m < 3; m++) begin
      step();
      chk("t4_pre_tick", 32'(tick[2]), 32'(0));
    end
    en = 4'b0011;
    for (int m = 0; m < 2; m++) begin
      step();
      chk("t4_off_tick", 32'(tick[2]), 32'(0));
      chk("t4_off_sq", 32'(sq[2]), 32'(0));
    end
    en = 4'b0111;
    for (int r = 1; r <= 7; r++) begin
      step();
      chk("t4_re_tick", 32'(tick[2]), 32'(r == 6));
      chk("t4_re_sq", 32'(sq[2]), 32'(r >= 4 && r <= 6));
    end

    // 5: sync_clr aligns ch0 (6), ch1 (5), ch2 (6), ch3 (4)
    wr(3'd0, 32'd6, "t5_rdy0");
    wr(3'd3, 32'd4, "t5_rdy3");
    en = 4'b1111;
    nwait = int'($urandom_range(3, 11));
    repeat (nwait) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    chk("t5_clr_tick", 32'(tick), 32'(0));
    for (int s = 1; s <= 8; s++) begin
      step();
      e = {s == 4 || s == 8, s == 6, s == 5, s == 6};
      chk("t5_tick", 32'(tick), 32'(e));
    end

    // 6: write to channel 4 is rejected with an error pulse
    cfg.cfg_ch = 3'd4;
    cfg.cfg_div = 32'd2;
    #1;
    chk("t6_rdy_oor", 32'(cfg.cfg_ready), 32'(1));
    cfg.cfg_valid = 1'b1;
    step();
    chk("t6_err_hi", 32'(cfg.cfg_err), 32'(1));
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch = 3'd0;
    step();
    chk("t6_err_lo", 32'(cfg.cfg_err), 32'(0));
    chk("t6_rdy_ch0", 32'(cfg.cfg_ready), 32'(1));
    step();
    step();
    chk("t6_tick12", 32'(tick), 32'(4'b1101));
    for (int s = 13; s <= 18; s++) begin
      step();
      chk("t6_tick0", 32'(tick[0]), 32'(s == 18));
    end

    // async reset while a write is pending
    wr(3'd0, 32'd3, "t7_rdy");
    chk("t7_pend", 32'(cfg.cfg_ready), 32'(0));
    #3;
    rst = 1'b1;
    #1;
    chk("t7_rst_tick", 32'(tick), 32'(0));
    chk("t7_rst_sq", 32'(sq), 32'(0));
    chk("t7_rst_rdy", 32'(cfg.cfg_ready), 32'(1));
    step();
    step();
    en = 4'b0001;
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("t7_tick0", 32'(tick[0]), 32'(k % 8 == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
